osd_page_sched: RTL and testbench

Frame-synchronous page scheduler for the OSD overlay path. It takes debounced key pulses and the vertical sync from the pixel timing chain, and selects which character page the overlay shows. It produces a page index and a base address into a unified glyph ROM. It also produces an overlay enable. All visible changes happen only at frame start, so a page never switches mid-frame.

---
 rtl/osd_pkg.sv | 27 ++
 rtl/vs_sof_detect.sv | 22 ++
 rtl/osd_page_sched.sv | 153 +++++++++++++++
 tb/tb_osd_page_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// rtl/osd_pkg.sv - shared types and helpers for the OSD overlay blocks
package osd_pkg;

    localparam int PAGE_SEL_W = 3;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_HIDDEN = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_BACK = 2'd2
    } step_e;

    // Mode key cycles MANUAL -> AUTO -> HIDDEN -> MANUAL
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_MANUAL: next_mode = MODE_AUTO;
            MODE_AUTO:   next_mode = MODE_HIDDEN;
            default:     next_mode = MODE_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/vs_sof_detect.sv
// rtl/vs_sof_detect.sv - vertical sync falling-edge detector (frame start)
module vs_sof_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vs_i,
    output logic sof_o
);

    logic vs_q;

    // Previous vsync sample; a high sample followed by a low input marks frame start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_i;
        end
    end

    assign sof_o = vs_q & ~vs_i;

endmodule

// File: rtl/osd_page_sched.sv
// rtl/osd_page_sched.sv - frame-synchronous OSD page, mode and ROM base scheduler
module osd_page_sched
    import osd_pkg::*;
#(
    parameter int PAGES       = 5,
    parameter int PAGE_WORDS  = 640,
    parameter int ADDR_W      = 16,
    parameter int AUTO_FRAMES = 60
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  i_vs,
    input  logic                  key_next,
    input  logic                  key_prev,
    input  logic                  key_mode,
    output logic [PAGE_SEL_W-1:0] page_sel,
    output logic [ADDR_W-1:0]     rom_base,
    output logic                  osd_en,
    output logic                  auto_on,
    output logic                  sof
);

    localparam int CNT_W = $clog2(AUTO_FRAMES) + 1;

    localparam logic [ADDR_W-1:0]     PAGE_STEP = ADDR_W'(PAGE_WORDS);
    localparam logic [ADDR_W-1:0]     LAST_BASE = ADDR_W'((PAGES - 1) * PAGE_WORDS);
    localparam logic [PAGE_SEL_W-1:0] LAST_PAGE = PAGE_SEL_W'(PAGES - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(AUTO_FRAMES - 1);

    logic sof_int;

    mode_e                 mode_q,      mode_d;
    logic                  mode_pend_q, mode_pend_d;
    step_e                 step_pend_q, step_pend_d;
    step_e                 do_step;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [PAGE_SEL_W-1:0] page_q,      page_d;
    logic [ADDR_W-1:0]     base_q,      base_d;
    logic                  osd_en_q;
    logic                  auto_on_q;
    logic                  sof_q;

    vs_sof_detect u_sof (
        .clk_i  (pclk),
        .rst_ni (rst_n),
        .vs_i   (i_vs),
        .sof_o  (sof_int)
    );

    // Latch key requests between frames and resolve them at frame start
    always_comb begin
        mode_d      = mode_q;
        mode_pend_d = mode_pend_q | key_mode;
        cnt_d       = cnt_q;
        page_d      = page_q;
        base_d      = base_q;
        do_step     = STEP_NONE;

        // At frame start the pending step is consumed; a key in that same
        // cycle is kept for the following frame.
        step_pend_d = sof_int ? STEP_NONE : step_pend_q;
        if (mode_q != MODE_HIDDEN) begin
            if (key_next && !key_prev) begin
                step_pend_d = STEP_FWD;
            end else if (key_prev && !key_next) begin
                step_pend_d = STEP_BACK;
            end
        end

        if (sof_int) begin
            mode_pend_d = key_mode;

            // The step decision uses the mode that was active for the ending frame
            if (mode_q != MODE_HIDDEN) begin
                if (step_pend_q != STEP_NONE) begin
                    do_step = step_pend_q;
                    cnt_d   = '0;
                end else if (mode_q == MODE_AUTO && cnt_q == CNT_LAST) begin
                    do_step = STEP_FWD;
                    cnt_d   = '0;
                end else if (mode_q == MODE_AUTO) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end

            if (mode_pend_q) begin
                mode_d = next_mode(mode_q);
            end

            if (mode_d == MODE_HIDDEN) begin
                step_pend_d = STEP_NONE;
                cnt_d       = '0;
            end
        end

        // Base address tracks the page by add/subtract so no multiplier is needed
        case (do_step)
            STEP_FWD: begin
                if (page_q == LAST_PAGE) begin
                    page_d = '0;
                    base_d = '0;
                end else begin
                    page_d = page_q + PAGE_SEL_W'(1);
                    base_d = base_q + PAGE_STEP;
                end
            end
            STEP_BACK: begin
                if (page_q == '0) begin
                    page_d = LAST_PAGE;
                    base_d = LAST_BASE;
                end else begin
                    page_d = page_q - PAGE_SEL_W'(1);
                    base_d = base_q - PAGE_STEP;
                end
            end
            default: ;
        endcase
    end

    // Scheduler state and registered outputs, all changing together with sof
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_MANUAL;
            mode_pend_q <= 1'b0;
            step_pend_q <= STEP_NONE;
            cnt_q       <= '0;
            page_q      <= '0;
            base_q      <= '0;
            osd_en_q    <= 1'b1;
            auto_on_q   <= 1'b0;
            sof_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            mode_pend_q <= mode_pend_d;
            step_pend_q <= step_pend_d;
            cnt_q       <= cnt_d;
            page_q      <= page_d;
            base_q      <= base_d;
            osd_en_q    <= (mode_d != MODE_HIDDEN);
            auto_on_q   <= (mode_d == MODE_AUTO);
            sof_q       <= sof_int;
        end
    end

    assign page_sel = page_q;
    assign rom_base = base_q;
    assign osd_en   = osd_en_q;
    assign auto_on  = auto_on_q;
    assign sof      = sof_q;

endmodule

// File: tb/tb_osd_page_sched.sv
// tb/tb_osd_page_sched.sv - scoreboard bench for osd_page_sched
module tb_osd_page_sched;

    localparam int PAGES       = 5;
    localparam int PAGE_WORDS  = 640;
    localparam int ADDR_W      = 16;
    localparam int AUTO_FRAMES = 3;

    logic              pclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_vs = 1'b0;
    logic              key_next = 1'b0;
    logic              key_prev = 1'b0;
    logic              key_mode = 1'b0;
    logic [2:0]        page_sel;
    logic [ADDR_W-1:0] rom_base;
    logic              osd_en;
    logic              auto_on;
    logic              sof;

    osd_page_sched #(
        .PAGES       (PAGES),
        .PAGE_WORDS  (PAGE_WORDS),
        .ADDR_W      (ADDR_W),
        .AUTO_FRAMES (AUTO_FRAMES)
    ) dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .i_vs     (i_vs),
        .key_next (key_next),
        .key_prev (key_prev),
        .key_mode (key_mode),
        .page_sel (page_sel),
        .rom_base (rom_base),
        .osd_en   (osd_en),
        .auto_on  (auto_on),
        .sof      (sof)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int page;
        int base;
        int en;
        int au;
    } exp_t;

    exp_t sb[$];
    exp_t exp_cur;

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_sof   = 0;
    logic prev_sof = 1'b0;

    // Reference model: mode 0=MANUAL 1=AUTO 2=HIDDEN, step 0=NONE 1=FWD 2=BACK
    int m_page, m_mode, m_step, m_mpend, m_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_page = 0; m_mode = 0; m_step = 0; m_mpend = 0; m_cnt = 0;
        exp_cur.page = 0; exp_cur.base = 0; exp_cur.en = 1; exp_cur.au = 0;
    endtask

    task automatic model_keys(input bit n, input bit p, input bit m, input int gate_mode);
        if (m) m_mpend = 1;
        if (gate_mode != 2) begin
            if (n && !p)      m_step = 1;
            else if (p && !n) m_step = 2;
        end
        if (m_mode == 2) m_step = 0;
    endtask

    task automatic model_sof();
        exp_t e;
        int old_mode;
        int dir;
        old_mode = m_mode;
        dir = 0;
        if (old_mode != 2) begin
            if (m_step != 0) begin
                dir = m_step; m_step = 0; m_cnt = 0;
            end else if (old_mode == 1 && m_cnt == AUTO_FRAMES - 1) begin
                dir = 1; m_cnt = 0;
            end else if (old_mode == 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
            end
        end
        if (dir == 1) m_page = (m_page + 1) % PAGES;
        if (dir == 2) m_page = (m_page + PAGES - 1) % PAGES;
        if (m_mpend != 0) begin
            m_mode = (m_mode + 1) % 3;
            m_mpend = 0;
        end
        if (m_mode == 2) begin
            m_step = 0; m_cnt = 0;
        end
        e.page = m_page;
        e.base = m_page * PAGE_WORDS;
        e.en   = (m_mode != 2) ? 1 : 0;
        e.au   = (m_mode == 1) ? 1 : 0;
        sb.push_back(e);
        n_push++;
    endtask

    // Observe outputs on the falling edge: score each sof, and check that
    // nothing moves between frame starts.
    always @(negedge pclk) begin
        if (rst_n) begin
            if (sof) begin
                n_sof++;
                check("sof_width", int'(prev_sof), 0);
                check("sof_expected", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    exp_cur = sb.pop_front();
                end
                check("page_sel", int'(page_sel), exp_cur.page);
                check("rom_base", int'(rom_base), exp_cur.base);
                check("osd_en",   int'(osd_en),   exp_cur.en);
                check("auto_on",  int'(auto_on),  exp_cur.au);
            end else begin
                check("hold_page", int'(page_sel), exp_cur.page);
                check("hold_base", int'(rom_base), exp_cur.base);
                check("hold_en",   int'(osd_en),   exp_cur.en);
                check("hold_auto", int'(auto_on),  exp_cur.au);
            end
            prev_sof = sof;
        end else begin
            prev_sof = 1'b0;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 6 && sb.size() != 0; i++) @(posedge pclk);
        check("sof_seen", sb.size(), 0);
    endtask

    // One frame: vsync high for a few cycles then falling edge
    task automatic frame();
        @(posedge pclk); #1 i_vs = 1'b1;
        repeat (3) @(posedge pclk);
        #1 i_vs = 1'b0;
        model_sof();
        wait_drain();
        repeat (3) @(posedge pclk);
    endtask

    // Frame whose falling-edge cycle also carries a key_next pulse
    task automatic frame_key_at_sof();
        int old_mode;
        @(posedge pclk); #1 i_vs = 1'b1;
        repeat (3) @(posedge pclk);
        #1 i_vs = 1'b0; key_next = 1'b1;
        old_mode = m_mode;
        model_sof();
        model_keys(1, 0, 0, old_mode);
        @(posedge pclk); #1 key_next = 1'b0;
        wait_drain();
        repeat (3) @(posedge pclk);
    endtask

    task automatic press(input bit n, input bit p, input bit m);
        @(posedge pclk); #1 key_next = n; key_prev = p; key_mode = m;
        model_keys(n, p, m, m_mode);
        @(posedge pclk); #1 key_next = 1'b0; key_prev = 1'b0; key_mode = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_page", int'(page_sel), 0);
        check("rst_base", int'(rom_base), 0);
        check("rst_en",   int'(osd_en),   1);
        check("rst_auto", int'(auto_on),  0);
        check("rst_sof",  int'(sof),      0);
        @(posedge pclk); #1 rst_n = 1'b1;

        // Steady vsync low then high: no frame start
        repeat (20) @(posedge pclk);
        #1 i_vs = 1'b1;
        repeat (20) @(posedge pclk);

        // Reset and first frames, no keys
        repeat (3) frame();

        // Forward wrap
        for (int i = 0; i < 6; i++) begin
            press(1, 0, 0);
            frame();
        end

        // Back to page 0, then back wrap
        while (m_page != 0) begin
            press(0, 1, 0);
            frame();
        end
        press(0, 1, 0);
        frame();
        check("back_wrap_page", m_page, PAGES - 1);

        // Next then prev in one frame: last wins
        press(1, 0, 0);
        press(0, 1, 0);
        frame();
        // Both in the same cycle: nothing
        press(1, 1, 0);
        frame();
        // Key in the sof cycle is latched for the following frame
        frame_key_at_sof();
        frame();

        // Auto mode, double mode press counts once
        press(0, 0, 1);
        press(0, 0, 1);
        repeat (4) frame();
        press(1, 0, 0);
        repeat (5) frame();

        // Hidden: key ignored, then back to manual
        press(0, 0, 1);
        frame();
        press(1, 0, 0);
        frame();
        press(0, 1, 0);
        frame();
        press(0, 0, 1);
        frame();
        press(0, 1, 0);
        frame();

        // Reach page 3, enter AUTO, leave FWD pending, then reset mid-frame
        for (int i = 0; i < 2 * PAGES && m_page != 3; i++) begin
            press(1, 0, 0);
            frame();
        end
        press(0, 0, 1);
        frame();
        press(1, 0, 0);
        @(posedge pclk); #1 i_vs = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_page", int'(page_sel), 0);
        check("mid_rst_base", int'(rom_base), 0);
        check("mid_rst_en",   int'(osd_en),   1);
        check("mid_rst_auto", int'(auto_on),  0);
        check("mid_rst_sof",  int'(sof),      0);
        model_reset();
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;
        repeat (2) frame();

        repeat (5) @(posedge pclk);
        check("sb_drained", sb.size(), 0);
        check("sof_count", n_sof, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
